// File: rtl/rs_syndrome_calc.sv
// RS(15,11) syndrome calculator over GF(16) (x^4+x+1), roots alpha^0..alpha^3.
// Horner accumulation per symbol, result handed off through a single-entry valid/ready register.
module rs_syndrome_calc #(
  parameter int N    = 15,
  parameter int NSYN = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [3:0]        sym_in,
  input  logic              sym_valid,
  input  logic              sym_first,
  output logic [4*NSYN-1:0] syn_out,
  output logic              syn_err,
  output logic              syn_valid,
  input  logic              syn_ready,
  output logic              overrun,
  output logic              framing_err
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [3:0]  s0, s1, s2, s3;
  logic [3:0]  h0, h1, h2, h3;
  logic [15:0] next_syn;
  logic        complete;

  // Multiply by alpha: shift up, fold x^4 back in as x+1.
  function automatic logic [3:0] mul_a(input logic [3:0] v);
    mul_a = {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
  endfunction

  always_comb begin
    h0       = s0 ^ sym_in;
    h1       = mul_a(s1) ^ sym_in;
    h2       = mul_a(mul_a(s2)) ^ sym_in;
    h3       = mul_a(mul_a(mul_a(s3))) ^ sym_in;
    next_syn = {h3, h2, h1, h0};
    complete = (state == ACCUM) && sym_valid && !sym_first && (count == 4'(N - 1));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      count       <= '0;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      syn_out     <= '0;
      syn_err     <= 1'b0;
      syn_valid   <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      // A completing codeword may replace a result that is being drained this same cycle.
      if (complete) begin
        if (!syn_valid || syn_ready) begin
          syn_out   <= next_syn;
          syn_err   <= |next_syn;
          syn_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (syn_valid && syn_ready) begin
        syn_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sym_valid && sym_first) begin
            s0    <= sym_in;
            s1    <= sym_in;
            s2    <= sym_in;
            s3    <= sym_in;
            count <= 4'd1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (sym_valid) begin
            if (sym_first) begin
              framing_err <= 1'b1;
              s0          <= sym_in;
              s1          <= sym_in;
              s2          <= sym_in;
              s3          <= sym_in;
              count       <= 4'd1;
            end else if (complete) begin
              count <= '0;
              state <= IDLE;
            end else begin
              s0    <= h0;
              s1    <= h1;
              s2    <= h2;
              s3    <= h3;
              count <= count + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
- Decoder-side stage that sits directly downstream of the RS(15,11) systematic encoder / channel.
- Consumes a stream of 4-bit GF(16) symbols, 15 per codeword, highest-degree coefficient first (11 data symbols, then 4 parity).
- Computes syndromes S_j = r(alpha^j) for j = 0..3 by Horner's rule.
- Presents them, with an error flag, through a single-entry valid/ready output register to the downstream key-equation solver.

Parameters:
- N, 15, symbols per codeword; the block assumes exactly 15, other values unsupported.
- NSYN, 4, number of syndromes (2t); fixed at 4.

Ports:
- sys_clk  input  1  system clock, all state on rising edge
- sys_rst_n  input  1  asynchronous active-low reset
- sym_in  input  4  received symbol
- sym_valid  input  1  sym_in valid this cycle; always accepted, no backpressure
- sym_first  input  1  qualifies sym_valid: this symbol is degree 14 (start of codeword)
- syn_out  output  16  {S3,S2,S1,S0}, each 4 bits
- syn_err  output  1  1 when any syndrome is nonzero
- syn_valid  output  1  syn_out/syn_err hold a completed codeword's result
- syn_ready  input  1  downstream accepts result when syn_valid && syn_ready
- overrun  output  1  sticky: a result was lost because the holding register was full
- framing_err  output  1  sticky: sym_first seen mid-codeword

Behaviour:
- Field: GF(16), primitive polynomial x^4+x+1, alpha = 4'b0010. Roots alpha^0..alpha^3 (FCR = 0), matching generator x^4 + a^12 x^3 + a^4 x^2 + x + a^6.
- Constant multipliers by alpha^1, alpha^2, alpha^3 are XOR networks. Multiply by alpha^0 is identity.
- Reset (async, sys_rst_n = 0): accumulators S0..S3 = 0, symbol counter = 0, state = IDLE. syn_out = 0, syn_err = 0, syn_valid = 0, overrun = 0, framing_err = 0.
- States:
  - IDLE: ignore sym_valid unless sym_first = 1. On sym_valid && sym_first: S_j <= sym_in for all j, counter <= 1, go to ACCUM.
  - ACCUM, on each sym_valid with sym_first = 0: S_j <= (S_j * alpha^j) ^ sym_in, counter <= counter + 1. Cycles without sym_valid hold all state (gaps allowed).
  - ACCUM completion: the symbol accepted at counter = 14 completes the codeword. Next-state syndromes are written to the holding register, and syn_valid rises the following cycle. Latency is 1 cycle from the last symbol to syn_valid. Counter <= 0, go to IDLE.
  - sym_first during ACCUM: set framing_err, discard the partial codeword, and restart accumulation with this symbol as degree 14 (counter <= 1).
  - Back-to-back: a sym_first on the cycle immediately after completion is accepted (IDLE handles it in the same cycle).
- Holding register:
  - Loaded on completion if it is empty, or if it is being drained the same cycle (syn_valid && syn_ready). In that case the new result replaces it and syn_valid stays 1.
  - If full and not drained on completion: keep the old result, set overrun, and drop the new result.
  - syn_valid clears on handshake when no new result arrives.
  - syn_out/syn_err are stable while syn_valid = 1 and not yet accepted. syn_err = |syn_out, registered with it.
- Sticky flags clear only on reset.
- Reset mid-codeword: the partial codeword is discarded, and no syn_valid is produced for it.

Test Plan:
- All-zero codeword (sym_first on symbol 0, 15 zeros) -> syn_valid one cycle after the 15th symbol; syn_out = 16'h0000, syn_err = 0.
- Valid encoder codeword: data 1..11 plus encoder-generated parity -> syn_out = 0, syn_err = 0.
- Zero codeword with the first symbol = 4'h1 (error at degree 14) -> syn_out = 16'hFD91 (S0=1, S1=9, S2=D, S3=F), syn_err = 1.
- Zero codeword with the last symbol = 4'h1 (degree 0) -> syn_out = 16'h1111. Repeat with random sym_valid gaps: identical result.
- syn_ready held 0 while two codewords complete -> first result retained, overrun = 1. Then same-cycle drain+complete with syn_ready = 1 -> new result loaded, syn_valid stays 1, overrun unchanged.
- sym_first asserted at symbol 7, then a full 15-symbol zero codeword -> framing_err = 1, exactly one result with syn_out = 0. sys_rst_n pulsed mid-codeword -> all outputs 0, no syn_valid.
